// File: rtl/cmlk_sysctrl_pkg.sv
// Shared constants, state types and the byte-strobe merge helper for the
// cmlk system-control AXI4-Lite register file.
package cmlk_sysctrl_pkg;

    localparam int unsigned NUM_REGS = 4;

    localparam logic [3:0] REG0_OFF = 4'h0;
    localparam logic [3:0] REG1_OFF = 4'h4;
    localparam logic [3:0] REG2_OFF = 4'h8;
    localparam logic [3:0] REG3_OFF = 4'hC;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {WIdle, WResp} wr_state_e;
    typedef enum logic {RIdle, RData} rd_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cmlk_sysctrl_axil_regs_if.sv
// AXI4-Lite bus bundle for the S00_AXI port of the system-control register file.
interface cmlk_sysctrl_axil_regs_if #(
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned DataWidth = 32
);
    logic [AddrWidth-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [AddrWidth-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [DataWidth-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/cmlk_sysctrl_axil_regs.sv
// AXI4-Lite slave holding four RW control registers with byte strobes; all
// bus outputs come straight from flops.
module cmlk_sysctrl_axil_regs
    import cmlk_sysctrl_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_aresetn,
    cmlk_sysctrl_axil_regs_if.slave                s00_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_reg_o,
    output logic [NUM_REGS-1:0]                    ctrl_wr_pulse_o
);

    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                         pulse_q, pulse_d;

    wr_state_e                     wr_q, wr_d;
    logic                          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [31:0]                   wdata_q, wdata_d;
    logic [3:0]                    wstrb_q, wstrb_d;
    logic                          awready_q, awready_d, wready_q, wready_d;
    logic                          bvalid_q, bvalid_d;

    rd_state_e   rd_q, rd_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic        aw_hs, w_hs, ar_hs;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    assign aw_hs = awready_q & s00_axi.awvalid;
    assign w_hs  = wready_q & s00_axi.wvalid;
    assign ar_hs = arready_q & s00_axi.arvalid;

    // A handshake on the committing edge bypasses the capture flops.
    assign wr_idx  = aw_hs ? s00_axi.awaddr[3:2] : aw_addr_q[3:2];
    assign wr_data = w_hs ? s00_axi.wdata : wdata_q;
    assign wr_strb = w_hs ? s00_axi.wstrb : wstrb_q;

    always_comb begin
        wr_d      = wr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_addr_d = aw_addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        regs_d    = regs_q;
        pulse_d   = '0;
        case (wr_q)
            WIdle: begin
                if (aw_hs) aw_addr_d = s00_axi.awaddr;
                if (w_hs) begin
                    wdata_d = s00_axi.wdata;
                    wstrb_d = s00_axi.wstrb;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    regs_d[wr_idx]  = strb_merge(regs_q[wr_idx], wr_data, wr_strb);
                    pulse_d[wr_idx] = 1'b1;
                    bvalid_d        = 1'b1;
                    awready_d       = 1'b0;
                    wready_d        = 1'b0;
                    aw_done_d       = 1'b0;
                    w_done_d        = 1'b0;
                    wr_d            = WResp;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                    awready_d = ~(aw_done_q | aw_hs);
                    wready_d  = ~(w_done_q | w_hs);
                end
            end
            WResp: begin
                if (s00_axi.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wr_d      = WIdle;
                end
            end
            default: wr_d = WIdle;
        endcase
    end

    // Reads sample regs_q, so a same-edge write is not yet visible.
    always_comb begin
        rd_d      = rd_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (rd_q)
            RIdle: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rdata_d   = regs_q[s00_axi.araddr[3:2]];
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rd_d      = RData;
                end
            end
            RData: begin
                if (s00_axi.rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rd_d      = RIdle;
                end
            end
            default: rd_d = RIdle;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            regs_q    <= '0;
            pulse_q   <= '0;
            wr_q      <= WIdle;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rd_q      <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            pulse_q   <= pulse_d;
            wr_q      <= wr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            aw_addr_q <= aw_addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            rd_q      <= rd_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = wready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = RESP_OKAY;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = RESP_OKAY;

    assign ctrl_reg_o      = regs_q;
    assign ctrl_wr_pulse_o = pulse_q;

    logic unused_sigs;
    assign unused_sigs = ^{s00_axi.awprot, s00_axi.arprot, aw_addr_q[1:0], s00_axi.araddr[1:0]};

endmodule

// File: tb/tb_cmlk_sysctrl_axil_regs.sv
// Self-checking bench: directed scenarios plus random transactions against an
// array-based register model.
module tb_cmlk_sysctrl_axil_regs;
    import cmlk_sysctrl_pkg::*;

    logic         clk;
    logic         aresetn;
    logic [127:0] ctrl_reg;
    logic [3:0]   ctrl_pulse;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [4];

    cmlk_sysctrl_axil_regs_if #(.AddrWidth(4), .DataWidth(32)) axi ();

    cmlk_sysctrl_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi         (axi.slave),
        .ctrl_reg_o      (ctrl_reg),
        .ctrl_wr_pulse_o (ctrl_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500us");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs, w_hs;
        int cyc = 0;
        int idx;
        idx = int'(addr[3:2]);
        while (!(aw_done && w_done) && cyc <= 40) begin
            @(negedge clk);
            check("awready_state", axi.awready, !aw_done);
            check("wready_state", axi.wready, !w_done);
            check("bvalid_before_commit", axi.bvalid, 1'b0);
            axi.awaddr  = addr;
            axi.wdata   = data;
            axi.wstrb   = strb;
            axi.awvalid = !aw_done && (cyc >= aw_dly);
            axi.wvalid  = !w_done && (cyc >= w_dly);
            axi.bready  = 1'b0;
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            @(posedge clk);
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
            cyc++;
        end
        if (!(aw_done && w_done)) begin
            check("write_accept_timeout", {aw_done, w_done}, 2'b11);
            axi.awvalid = 1'b0;
            axi.wvalid  = 1'b0;
            return;
        end
        model_write(idx, data, strb);
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        check("bvalid_after_commit", axi.bvalid, 1'b1);
        check("bresp", axi.bresp, RESP_OKAY);
        check("regs_after_commit", ctrl_reg, model_flat());
        check("wr_pulse", ctrl_pulse, 4'b0001 << idx);
        check("awready_in_resp", axi.awready, 1'b0);
        check("wready_in_resp", axi.wready, 1'b0);
        repeat (b_dly) begin
            @(negedge clk);
            check("bvalid_held", axi.bvalid, 1'b1);
            check("awready_stall", axi.awready, 1'b0);
            check("wready_stall", axi.wready, 1'b0);
            check("pulse_single", ctrl_pulse, 4'b0000);
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("bvalid_cleared", axi.bvalid, 1'b0);
        check("awready_back", axi.awready, 1'b1);
        check("wready_back", axi.wready, 1'b1);
        check("pulse_done", ctrl_pulse, 4'b0000);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_dly, input logic [31:0] exp);
        @(negedge clk);
        check("arready_idle", axi.arready, 1'b1);
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b0;
        @(negedge clk);
        axi.arvalid = 1'b0;
        check("rvalid", axi.rvalid, 1'b1);
        check("rdata", axi.rdata, exp);
        check("rresp", axi.rresp, RESP_OKAY);
        check("arready_busy", axi.arready, 1'b0);
        repeat (r_dly) begin
            @(negedge clk);
            check("rvalid_held", axi.rvalid, 1'b1);
            check("rdata_stable", axi.rdata, exp);
        end
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        check("rvalid_cleared", axi.rvalid, 1'b0);
        check("arready_back", axi.arready, 1'b1);
    endtask

    initial begin
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        for (int i = 0; i < 4; i++) model[i] = '0;
        aresetn     = 1'b0;
        axi.awaddr  = '0;
        axi.awprot  = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.araddr  = '0;
        axi.arprot  = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_awready", axi.awready, 1'b0);
        check("rst_wready", axi.wready, 1'b0);
        check("rst_arready", axi.arready, 1'b0);
        check("rst_bvalid", axi.bvalid, 1'b0);
        check("rst_rvalid", axi.rvalid, 1'b0);
        check("rst_rdata", axi.rdata, 32'h0);
        check("rst_regs", ctrl_reg, 128'h0);
        check("rst_pulse", ctrl_pulse, 4'h0);
        aresetn = 1'b1;
        @(negedge clk);
        check("post_rst_awready", axi.awready, 1'b1);
        check("post_rst_wready", axi.wready, 1'b1);
        check("post_rst_arready", axi.arready, 1'b1);

        // Basic write then read-back of all four registers.
        for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0, 32'(i + 1));
        check("basic_regs", ctrl_reg, {32'h4, 32'h3, 32'h2, 32'h1});

        // Byte strobes.
        axi_write(4'h4, 32'h11111111, 4'hF, 0, 0, 0);
        axi_write(4'h4, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        axi_read(4'h4, 0, 32'h11BB11DD);

        // AW leading W and W leading AW.
        axi_write(4'h8, 32'hCAFE0001, 4'hF, 0, 3, 0);
        axi_write(4'h8, 32'hCAFE0002, 4'hF, 3, 0, 0);
        axi_read(4'h8, 0, 32'hCAFE0002);

        // Back-pressure on B and R, and an all-zero strobe.
        axi_write(4'hC, 32'h0BADF00D, 4'hF, 0, 0, 5);
        axi_read(4'hC, 5, 32'h0BADF00D);
        axi_write(4'hC, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
        axi_read(4'hC, 0, 32'h0BADF00D);

        // Read and write of reg2 on the same edge.
        axi_write(4'h8, 32'h5, 4'hF, 0, 0, 0);
        @(negedge clk);
        axi.awaddr  = 4'h8;
        axi.wdata   = 32'h9;
        axi.wstrb   = 4'hF;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        axi.araddr  = 4'h8;
        axi.arvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.arvalid = 1'b0;
        model[2] = 32'h9;
        check("same_edge_rvalid", axi.rvalid, 1'b1);
        check("same_edge_rdata_old", axi.rdata, 32'h5);
        check("same_edge_bvalid", axi.bvalid, 1'b1);
        check("same_edge_reg_new", ctrl_reg, model_flat());
        axi.bready = 1'b1;
        axi.rready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        axi.rready = 1'b0;
        check("same_edge_b_done", axi.bvalid, 1'b0);
        check("same_edge_r_done", axi.rvalid, 1'b0);
        axi_read(4'h8, 0, 32'h9);

        // Random traffic; address low bits are random and must be ignored.
        for (int n = 0; n < 40; n++) begin
            a = 4'($urandom);
            d = $urandom;
            s = 4'($urandom);
            if ($urandom_range(0, 1) == 0)
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3));
            else
                axi_read(a, $urandom_range(0, 3), model[a[3:2]]);
        end
        check("random_regs", ctrl_reg, model_flat());

        // Reset while a write response is pending.
        @(negedge clk);
        axi.awaddr  = 4'h4;
        axi.wdata   = 32'h12345678;
        axi.wstrb   = 4'hF;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        check("pre_rst_bvalid", axi.bvalid, 1'b1);
        aresetn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) model[i] = '0;
        check("mid_rst_bvalid", axi.bvalid, 1'b0);
        check("mid_rst_regs", ctrl_reg, model_flat());
        check("mid_rst_awready", axi.awready, 1'b0);
        check("mid_rst_pulse", ctrl_pulse, 4'h0);
        aresetn = 1'b1;
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("post_mid_rst_bvalid", axi.bvalid, 1'b0);
        check("post_mid_rst_awready", axi.awready, 1'b1);
        axi_write(4'hC, 32'h600DD00D, 4'hF, 1, 2, 1);
        axi_read(4'hC, 1, 32'h600DD00D);
        axi_read(4'h4, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
